mem_arbiter_rr2: RTL and testbench

MEM_ARBITER_RR2 -- requirements
Module: mem_arbiter_rr2

---
 rtl/mem_arbiter_rr2.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter_rr2.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr2.sv
// Two-master round-robin arbiter for a single shared valid/ready memory bus.
// One transaction is in flight at a time. Every completion, timeout or
// protocol abort returns the arbiter to IDLE for at least one cycle before
// the next grant. A per-transaction wait counter forces completion with
// ERR_DATA when the slave stalls for TIMEOUT cycles.
module mem_arbiter_rr2 #(
    parameter int unsigned  TIMEOUT  = 64,
    parameter logic [31:0]  ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        grant_id,
    output logic        timeout_err,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Counter value seen in the last cycle a stalled transaction may wait.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        armed;
    logic [7:0]  wait_cnt;

    logic        grant_en;
    logic        grant_sel;
    logic        owner;
    logic        owner_valid;
    logic        done;
    logic [31:0] done_rdata;

    // Next-state, grant decision and combinational completion outputs.
    always_comb begin
        state_nxt   = state;
        grant_en    = 1'b0;
        grant_sel   = 1'b0;
        owner       = 1'b0;
        owner_valid = 1'b0;
        done        = 1'b0;
        done_rdata  = 32'h0;
        timeout_err = 1'b0;
        proto_err   = 1'b0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = 32'h0;
        m1_rdata    = 32'h0;

        case (state)
            IDLE: begin
                // armed holds off the first grant until the second edge after reset release.
                if (armed) begin
                    if (m0_valid && m1_valid) begin
                        grant_en  = 1'b1;
                        grant_sel = ~last_grant;
                    end else if (m0_valid) begin
                        grant_en  = 1'b1;
                        grant_sel = 1'b0;
                    end else if (m1_valid) begin
                        grant_en  = 1'b1;
                        grant_sel = 1'b1;
                    end
                end
                if (grant_en) begin
                    state_nxt = grant_sel ? GRANT1 : GRANT0;
                end
            end

            GRANT0, GRANT1: begin
                owner       = (state == GRANT1);
                owner_valid = owner ? m1_valid : m0_valid;
                if (!owner_valid) begin
                    // Owner withdrew its request: abort without a ready pulse.
                    proto_err = 1'b1;
                    state_nxt = IDLE;
                end else if (mem_ready) begin
                    // A real slave response wins over a coincident timeout.
                    done       = 1'b1;
                    done_rdata = mem_rdata;
                    state_nxt  = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done        = 1'b1;
                    done_rdata  = ERR_DATA;
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (done && !owner) begin
            m0_ready = 1'b1;
            m0_rdata = done_rdata;
        end
        if (done && owner) begin
            m1_ready = 1'b1;
            m1_rdata = done_rdata;
        end
    end

    // State register, round-robin history, grant arming and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            armed      <= 1'b0;
            wait_cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (grant_en) begin
                last_grant <= grant_sel;
                wait_cnt   <= 8'd0;
            end else if ((state != IDLE) && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Shared-bus request registers: loaded on grant, held until the transaction ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            grant_id  <= 1'b0;
        end else if (grant_en) begin
            mem_valid <= 1'b1;
            grant_id  <= grant_sel;
            mem_instr <= grant_sel ? m1_instr : m0_instr;
            mem_addr  <= grant_sel ? m1_addr  : m0_addr;
            mem_wdata <= grant_sel ? m1_wdata : m0_wdata;
            mem_wstrb <= grant_sel ? m1_wstrb : m0_wstrb;
        end else if ((state != IDLE) && (state_nxt == IDLE)) begin
            mem_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr2.sv
// Scoreboard bench for mem_arbiter_rr2. Instance 0 uses the default TIMEOUT,
// instance 1 uses TIMEOUT=4. Stimulus pushes the expected completion event
// right before the cycle it must appear in; a monitor checks every ready or
// error pulse against the queue and flags pulses nobody expected.
module tb_mem_arbiter_rr2;

    typedef struct {
        int          d;
        logic [1:0]  rdy;
        logic [31:0] rdata;
        logic        te;
        logic        pe;
    } exp_t;

    logic        clk;
    logic        reset;

    logic [1:0]  mv  [2];
    logic [1:0]  mi  [2];
    logic [1:0]  mr  [2];
    logic [31:0] ma  [2][2];
    logic [31:0] mw  [2][2];
    logic [31:0] mrd [2][2];
    logic [3:0]  ms  [2][2];

    logic        mem_valid [2];
    logic        mem_instr [2];
    logic        mem_ready [2];
    logic        grant_id  [2];
    logic        terr      [2];
    logic        perr      [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [3:0]  mem_wstrb [2];

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Contention rounds: expected winner, its address and the slave data returned.
    logic        win_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] addr_tab [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    logic [31:0] data_tab [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

    mem_arbiter_rr2 dut0 (
        .clk(clk), .reset(reset),
        .m0_valid(mv[0][0]), .m0_instr(mi[0][0]), .m0_addr(ma[0][0]), .m0_wdata(mw[0][0]),
        .m0_wstrb(ms[0][0]), .m0_ready(mr[0][0]), .m0_rdata(mrd[0][0]),
        .m1_valid(mv[0][1]), .m1_instr(mi[0][1]), .m1_addr(ma[0][1]), .m1_wdata(mw[0][1]),
        .m1_wstrb(ms[0][1]), .m1_ready(mr[0][1]), .m1_rdata(mrd[0][1]),
        .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_ready(mem_ready[0]),
        .mem_rdata(mem_rdata[0]), .grant_id(grant_id[0]), .timeout_err(terr[0]),
        .proto_err(perr[0])
    );

    mem_arbiter_rr2 #(.TIMEOUT(4)) dut1 (
        .clk(clk), .reset(reset),
        .m0_valid(mv[1][0]), .m0_instr(mi[1][0]), .m0_addr(ma[1][0]), .m0_wdata(mw[1][0]),
        .m0_wstrb(ms[1][0]), .m0_ready(mr[1][0]), .m0_rdata(mrd[1][0]),
        .m1_valid(mv[1][1]), .m1_instr(mi[1][1]), .m1_addr(ma[1][1]), .m1_wdata(mw[1][1]),
        .m1_wstrb(ms[1][1]), .m1_ready(mr[1][1]), .m1_rdata(mrd[1][1]),
        .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_ready(mem_ready[1]),
        .mem_rdata(mem_rdata[1]), .grant_id(grant_id[1]), .timeout_err(terr[1]),
        .proto_err(perr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int d, input int n, input logic instr, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s);
        mi[d][n] = instr;
        ma[d][n] = a;
        mw[d][n] = w;
        ms[d][n] = s;
        mv[d][n] = 1'b1;
    endtask

    task automatic expect_evt(input int d, input logic [1:0] rdy, input logic [31:0] rd,
                              input logic te, input logic pe);
        exp_t e;
        e.d = d; e.rdy = rdy; e.rdata = rd; e.te = te; e.pe = pe;
        sb.push_back(e);
    endtask

    task automatic slave(input int d, input logic rdy, input logic [31:0] rd);
        mem_ready[d] = rdy;
        mem_rdata[d] = rd;
    endtask

    task automatic monitor();
        exp_t        e;
        logic [31:0] got_rd;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 2; n++) begin
                    if (!mr[d][n]) check("rdata_zero_when_not_ready", 64'(mrd[d][n]), 64'h0);
                end
                if ((mr[d] != 2'b00) || terr[d] || perr[d]) begin
                    got_rd = mr[d][1] ? mrd[d][1] : mrd[d][0];
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_event: dut%0d ready=%b rdata=%h terr=%b perr=%b, expected no event",
                                 d, mr[d], got_rd, terr[d], perr[d]);
                    end else begin
                        e = sb.pop_front();
                        check("completion_event",
                              64'({d[0], mr[d], got_rd, terr[d], perr[d]}),
                              64'({e.d[0], e.rdy, e.rdata, e.te, e.pe}));
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 2'b00;
            mi[d] = 2'b00;
            mem_ready[d] = 1'b0;
            mem_rdata[d] = 32'h0;
            for (int n = 0; n < 2; n++) begin
                ma[d][n] = 32'h0;
                mw[d][n] = 32'h0;
                ms[d][n] = 4'h0;
            end
        end
        fork
            monitor();
        join_none

        #2 reset = 1'b1;
        repeat (3) tick();

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            check("reset_bus", 64'({mem_valid[d], mem_instr[d], mem_wstrb[d], grant_id[d]}), 64'h0);
            check("reset_addr_wdata", {mem_addr[d], mem_wdata[d]}, 64'h0);
            check("reset_ready_err", 64'({mr[d], terr[d], perr[d]}), 64'h0);
        end

        // Both masters request from reset: m0 first, then strict alternation.
        ma[0][0] = 32'h100;
        ma[0][1] = 32'h200;
        mv[0]    = 2'b11;
        reset    = 1'b0;
        tick();
        check("no_grant_first_edge", 64'(mem_valid[0]), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("contention_grant", 64'({mem_valid[0], grant_id[0]}), 64'({1'b1, win_tab[k]}));
            check("contention_addr", 64'(mem_addr[0]), 64'(addr_tab[k]));
            slave(0, 1'b1, data_tab[k]);
            expect_evt(0, win_tab[k] ? 2'b10 : 2'b01, data_tab[k], 1'b0, 1'b0);
            tick();
            slave(0, 1'b0, 32'h0);
            check("idle_gap_after_completion", 64'(mem_valid[0]), 64'h0);
        end
        mv[0] = 2'b00;

        // m0 fetch read at 0x100, slave answers 3 cycles after mem_valid; m1 waits meanwhile.
        tick();
        req(0, 0, 1'b1, 32'h100, 32'h0, 4'h0);
        tick();
        check("read_grant", 64'({mem_valid[0], grant_id[0], mem_instr[0], mem_wstrb[0]}), 64'({1'b1, 1'b0, 1'b1, 4'h0}));
        check("read_addr", 64'(mem_addr[0]), 64'h100);
        tick();
        req(0, 1, 1'b0, 32'h204, 32'h1234_5678, 4'hF);
        tick();
        tick();
        check("read_addr_stable", 64'({mem_valid[0], mem_addr[0]}), 64'({1'b1, 32'h100}));
        slave(0, 1'b1, 32'hCAFE_0100);
        expect_evt(0, 2'b01, 32'hCAFE_0100, 1'b0, 1'b0);
        tick();
        slave(0, 1'b0, 32'h0);
        mv[0][0] = 1'b0;
        check("read_done_idle", 64'(mem_valid[0]), 64'h0);

        // Pending m1 write is granted next and held stable over a 5-cycle stall.
        tick();
        check("write_grant", 64'({mem_valid[0], grant_id[0], mem_instr[0]}), 64'({1'b1, 1'b1, 1'b0}));
        for (int j = 0; j < 5; j++) begin
            check("write_addr_strb_stable", 64'({mem_valid[0], mem_wstrb[0], mem_addr[0]}), 64'({1'b1, 4'hF, 32'h204}));
            check("write_wdata_stable", 64'(mem_wdata[0]), 64'h1234_5678);
            if (j < 4) tick();
        end
        tick();
        slave(0, 1'b1, 32'h5A5A_5A5A);
        expect_evt(0, 2'b10, 32'h5A5A_5A5A, 1'b0, 1'b0);
        tick();
        slave(0, 1'b0, 32'h0);
        mv[0][1] = 1'b0;
        check("write_done_idle", 64'(mem_valid[0]), 64'h0);

        // Slave ready while idle is ignored.
        tick();
        slave(0, 1'b1, 32'h0000_0099);
        #2;
        check("idle_mem_ready_ignored", 64'({mr[0], terr[0], perr[0]}), 64'h0);
        tick();
        slave(0, 1'b0, 32'h0);
        check("idle_mem_ready_no_grant", 64'(mem_valid[0]), 64'h0);

        // Granted m1 withdraws its request: proto_err, no ready.
        tick();
        req(0, 1, 1'b0, 32'h208, 32'h0, 4'h0);
        tick();
        check("proto_grant", 64'({mem_valid[0], grant_id[0]}), 64'({1'b1, 1'b1}));
        mv[0][1] = 1'b0;
        expect_evt(0, 2'b00, 32'h0, 1'b0, 1'b1);
        tick();
        check("proto_abort_idle", 64'(mem_valid[0]), 64'h0);

        // Reset in the 2nd wait cycle aborts silently; pending m1 is served after release.
        tick();
        req(0, 0, 1'b0, 32'h10C, 32'h0, 4'h0);
        tick();
        req(0, 1, 1'b0, 32'h210, 32'h0, 4'h0);
        tick();
        check("pre_reset_owner", 64'({mem_valid[0], grant_id[0]}), 64'({1'b1, 1'b0}));
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid", 64'({mem_valid[0], mr[0]}), 64'h0);
        mv[0][0] = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_no_grant", 64'(mem_valid[0]), 64'h0);
        tick();
        check("post_reset_grant_m1", 64'({mem_valid[0], grant_id[0], mem_addr[0]}), 64'({1'b1, 1'b1, 32'h210}));
        slave(0, 1'b1, 32'h2100_0001);
        expect_evt(0, 2'b10, 32'h2100_0001, 1'b0, 1'b0);
        tick();
        slave(0, 1'b0, 32'h0);
        mv[0][1] = 1'b0;
        check("post_reset_done_idle", 64'(mem_valid[0]), 64'h0);

        // TIMEOUT=4, slave silent: the 4th grant cycle returns ERR_DATA with timeout_err.
        tick();
        req(1, 0, 1'b0, 32'h300, 32'h0, 4'h0);
        tick();
        check("to_grant", 64'({mem_valid[1], grant_id[1], mem_addr[1]}), 64'({1'b1, 1'b0, 32'h300}));
        tick();
        tick();
        tick();
        expect_evt(1, 2'b01, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        mv[1][0] = 1'b0;
        check("to_idle", 64'(mem_valid[1]), 64'h0);

        // TIMEOUT=4, slave answers in the 4th cycle: normal data, no timeout_err.
        tick();
        req(1, 0, 1'b0, 32'h304, 32'h0, 4'h0);
        tick();
        check("to_edge_grant", 64'({mem_valid[1], mem_addr[1]}), 64'({1'b1, 32'h304}));
        tick();
        tick();
        tick();
        slave(1, 1'b1, 32'h7777_0304);
        expect_evt(1, 2'b01, 32'h7777_0304, 1'b0, 1'b0);
        tick();
        slave(1, 1'b0, 32'h0);
        mv[1][0] = 1'b0;
        check("to_edge_idle", 64'(mem_valid[1]), 64'h0);

        tick();
        tick();
        check("all_expected_events_seen", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
